// File: rtl/spi_arb_pkg.sv
// Shared types and sizing for the SPI transaction arbiter.
// TXN_CYCLES is the fixed time from start_comm until the SPI controller's
// CIPO_register holds the received word.
package spi_arb_pkg;

  localparam int N_REQ            = 4;
  localparam int REQ_SEL          = 2;
  localparam int PERIPHERY_SELECT = 2;
  localparam int LENGTH_SEND_C    = 8;
  localparam int LENGTH_SEND_P    = 16;
  localparam int PAUSE            = 5;
  localparam int CNT_W            = 6;

  // Transmit bits + pause + receive bits + controller pipeline overhead.
  function automatic int txn_cycles(input int len_c, input int pause, input int len_p);
    return len_c + pause + len_p + 4;
  endfunction

  localparam int TXN_CYCLES = txn_cycles(LENGTH_SEND_C, PAUSE, LENGTH_SEND_P);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational request picker: scans the request vector starting at ptr
// and returns the first pending requester as a one-hot grant plus index.
// With ptr held at zero it degenerates to lowest-index-wins priority.
// N must equal 2**SEL so that ptr+k wraps naturally.
module spi_rr_picker #(
  parameter int N   = 4,
  parameter int SEL = 2
) (
  input  logic [N-1:0]   req,
  input  logic [SEL-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [SEL-1:0] idx,
  output logic           any
);

  logic [SEL-1:0] pos;

  // Walk the requesters from ptr upward; the first pending one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = ptr + SEL'(k);
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI controller between N_REQ requesters. One grant runs one
// complete SPI transaction, timed by a fixed-length counter, and the
// received word is returned to the granted requester as a one-cycle pulse.
// Optional feature macro: SPI_ARB_RR_EN selects round-robin arbitration;
// when undefined the lowest requester index always wins.
module spi_txn_arbiter
  import spi_arb_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ*PERIPHERY_SELECT-1:0]   req_cs,
  input  logic [N_REQ*LENGTH_SEND_C-1:0]      req_data,
  output logic [N_REQ-1:0]                    rsp_valid,
  output logic [LENGTH_SEND_P-1:0]            rsp_data,
  output logic                                busy,
  output logic                                start_comm,
  output logic [PERIPHERY_SELECT-1:0]         CS_in,
  output logic [LENGTH_SEND_C-1:0]            data_send_c,
  input  logic [LENGTH_SEND_P-1:0]            cipo_data
);

  localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(TXN_CYCLES - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);

  arb_state_t                  state_reg, state_next;
  logic [CNT_W-1:0]            timer_reg;
  logic [REQ_SEL-1:0]          win_reg;
  logic [PERIPHERY_SELECT-1:0] cs_reg;
  logic [LENGTH_SEND_C-1:0]    data_reg;
  logic [N_REQ-1:0]            rsp_valid_reg;
  logic [LENGTH_SEND_P-1:0]    rsp_data_reg;

  logic [N_REQ-1:0]            pick_grant;
  logic [REQ_SEL-1:0]          pick_idx;
  logic                        pick_any;
  logic [REQ_SEL-1:0]          pick_ptr;
  logic                        take_grant;

  // Per-requester views of the packed request buses.
  logic [PERIPHERY_SELECT-1:0] cs_arr   [N_REQ];
  logic [LENGTH_SEND_C-1:0]    data_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign cs_arr[gi]   = req_cs[gi*PERIPHERY_SELECT +: PERIPHERY_SELECT];
      assign data_arr[gi] = req_data[gi*LENGTH_SEND_C +: LENGTH_SEND_C];
    end
  endgenerate

  spi_rr_picker #(
    .N   (N_REQ),
    .SEL (REQ_SEL)
  ) u_picker (
    .req   (req_valid),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign take_grant = (state_reg == IDLE) && pick_any;

`ifdef SPI_ARB_RR_EN
  logic [REQ_SEL-1:0] ptr_reg;

  // Rotate the search start to just past the requester that was served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else if (take_grant) begin
      ptr_reg <= pick_idx + REQ_SEL'(1);
    end
  end

  assign pick_ptr = ptr_reg;
`else
  assign pick_ptr = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: one grant walks through a full timed transaction.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_any) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (timer_reg == '0) state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; grants are only offered while idle.
  always_comb begin
    req_ready  = '0;
    start_comm = 1'b0;
    busy       = (state_reg != IDLE);
    if (state_reg == IDLE) begin
      req_ready = pick_grant;
    end
    if (state_reg == START) begin
      start_comm = 1'b1;
    end
  end

  // Latch the winner's target and word at the grant; run the transaction timer.
  // The timer is loaded as the grant is taken so the START cycle is the first
  // timed cycle, which lands CAPTURE exactly TXN_CYCLES after start_comm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_reg   <= '0;
      cs_reg    <= '0;
      data_reg  <= '0;
      timer_reg <= '0;
    end else if (take_grant) begin
      win_reg   <= pick_idx;
      cs_reg    <= cs_arr[pick_idx];
      data_reg  <= data_arr[pick_idx];
      timer_reg <= TIMER_LOAD;
    end else if ((state_reg == START || state_reg == WAIT) && timer_reg != '0) begin
      timer_reg <= timer_reg - CNT_W'(1);
    end
  end

  // Capture the received word and pulse the response to the winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= '0;
      if (state_reg == CAPTURE) begin
        rsp_valid_reg <= ONE_HOT0 << win_reg;
        rsp_data_reg  <= cipo_data;
      end
    end
  end

  assign CS_in       = cs_reg;
  assign data_send_c = data_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter with a behavioural SPI peripheral
// model. A cycle-schedule model predicts grants, start_comm, busy and the
// response pulse; a scoreboard queue pairs each handshake with its response.
module tb_spi_txn_arbiter;
  import spi_arb_pkg::*;

`ifdef SPI_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic                              clk = 1'b0;
  logic                              rst = 1'b0;
  logic [N_REQ-1:0]                  req_valid = '0;
  logic [N_REQ-1:0]                  req_ready;
  logic [N_REQ*PERIPHERY_SELECT-1:0] req_cs = '0;
  logic [N_REQ*LENGTH_SEND_C-1:0]    req_data = '0;
  logic [N_REQ-1:0]                  rsp_valid;
  logic [LENGTH_SEND_P-1:0]          rsp_data;
  logic                              busy;
  logic                              start_comm;
  logic [PERIPHERY_SELECT-1:0]       CS_in;
  logic [LENGTH_SEND_C-1:0]          data_send_c;
  logic [LENGTH_SEND_P-1:0]          cipo_data;

  spi_txn_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cs      (req_cs),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .start_comm  (start_comm),
    .CS_in       (CS_in),
    .data_send_c (data_send_c),
    .cipo_data   (cipo_data)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SPI peripheral model ----------------
  // Each peripheral owns a response word; CIPO_register shows the inverted
  // word until TXN_CYCLES after start_comm, so an early capture is visible.
  logic [LENGTH_SEND_P-1:0] periph_word [4];
  logic [LENGTH_SEND_C-1:0] copi_reg    [4];
  logic [6:0]               pcnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
      for (int i = 0; i < 4; i++) copi_reg[i] <= '0;
    end else if (start_comm) begin
      pcnt            <= 7'd1;
      copi_reg[CS_in] <= data_send_c;
    end else if (pcnt != 7'd0 && pcnt != 7'h7F) begin
      pcnt <= pcnt + 7'd1;
    end
  end

  assign cipo_data = (pcnt >= 7'(TXN_CYCLES)) ? periph_word[CS_in] : ~periph_word[CS_in];

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int                       w;
    logic [1:0]               cs;
    logic [LENGTH_SEND_C-1:0] data;
    logic [LENGTH_SEND_P-1:0] word;
  } sb_t;

  sb_t  sb[$];
  int   grant_log[$];
  bit   tx_active = 1'b0;
  int   tx_h, tx_w, m_ptr = 0;
  logic [1:0]               tx_cs;
  logic [LENGTH_SEND_C-1:0] tx_data;
  logic [LENGTH_SEND_P-1:0] m_last_word = '0;
  int   last_hs_cyc = 0, last_rsp_cyc = 0, rsp_count = 0;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  sb_t  m_e;
  logic [3:0] m_exp_rsp, m_exp_ready;
  int   m_w;

  // Compare every DUT output against the schedule model once per cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start_comm", start_comm, 0);
      chk("rst_cs_in", CS_in, 0);
      chk("rst_data_send_c", data_send_c, 0);
      chk("rst_rsp_data", rsp_data, 0);
      tx_active   = 1'b0;
      m_ptr       = 0;
      m_last_word = '0;
      sb.delete();
    end else begin
      m_exp_rsp = '0;
      if (tx_active && cyc == tx_h + TXN_CYCLES + 2) begin
        m_exp_rsp = 4'(1) << tx_w;
        tx_active = 1'b0;
      end
      chk("rsp_valid", rsp_valid, m_exp_rsp);
      if (m_exp_rsp != 0) begin
        chk("sb_nonempty", sb.size(), 1);
        if (sb.size() != 0) begin
          m_e = sb.pop_front();
          chk("rsp_data", rsp_data, m_e.word);
          chk("copi_reg", copi_reg[m_e.cs], m_e.data);
          m_last_word = m_e.word;
          $display("rsp req=%0d cs=%0d sent=%02h got=%04h cycle=%0d", m_e.w, m_e.cs, m_e.data, rsp_data, cyc);
        end
        last_rsp_cyc = cyc;
        rsp_count++;
      end else begin
        chk("rsp_data_hold", rsp_data, m_last_word);
      end
      chk("busy", busy, tx_active);
      chk("start_comm", start_comm, tx_active && cyc == tx_h + 1);
      if (tx_active) begin
        chk("cs_in_stable", CS_in, tx_cs);
        chk("data_send_c_stable", data_send_c, tx_data);
      end
      m_exp_ready = '0;
      m_w = -1;
      if (!tx_active && req_valid != 0) begin
        m_w = pick(req_valid, m_ptr);
        m_exp_ready = 4'(1) << m_w;
      end
      chk("req_ready", req_ready, m_exp_ready);
      if (m_w >= 0) begin
        tx_active = 1'b1;
        tx_h      = cyc;
        tx_w      = m_w;
        tx_cs     = req_cs[m_w*2 +: 2];
        tx_data   = req_data[m_w*8 +: 8];
        sb.push_back('{m_w, tx_cs, tx_data, periph_word[tx_cs]});
        grant_log.push_back(m_w);
        last_hs_cyc = cyc;
        if (RR_MODE) m_ptr = (m_w + 1) % 4;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_grants(input int n, input int budget);
    int t = 0;
    while (grant_log.size() < n && t < budget) begin
      @(posedge clk); #1; t++;
    end
    chk("grant_wait", grant_log.size() >= n, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((tx_active || sb.size() != 0) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("idle_wait", tx_active, 0);
    @(posedge clk); #1;
  endtask

  // Requester i targets peripheral i with data_base^i; peripheral i answers word_base^(i*1111).
  task automatic fill(input logic [7:0] data_base, input logic [15:0] word_base);
    for (int i = 0; i < 4; i++) begin
      req_cs[i*2 +: 2]   = 2'(i);
      req_data[i*8 +: 8] = data_base ^ 8'(i);
      periph_word[i]     = word_base ^ (16'h1111 * 16'(i));
    end
  endtask

  task automatic apply(input logic [3:0] mask, output int w);
    int n0;
    n0 = grant_log.size();
    req_valid = mask;
    wait_grants(n0 + 1, 60);
    req_valid = '0;
    w = (grant_log.size() > n0) ? grant_log[n0] : -1;
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  mask;
    int          exp_fixed;
    int          exp_rr;
    logic [7:0]  data;
    logic [15:0] word;
  } vec_t;

  vec_t vecs [8];
  int   w, n0, h, rc0;
  int   exp_c [5];
  logic [3:0] rmask;

  initial begin
    for (int i = 0; i < 4; i++) periph_word[i] = '0;
    // Round-robin expectations assume the pointer starts at 0 after reset.
    vecs[0] = '{4'b0001, 0, 0, 8'hA5, 16'h3C5A};
    vecs[1] = '{4'b1010, 1, 1, 8'h11, 16'h4321};
    vecs[2] = '{4'b1010, 1, 3, 8'h22, 16'h9876};
    vecs[3] = '{4'b0110, 1, 1, 8'h33, 16'hCAFE};
    vecs[4] = '{4'b0101, 0, 2, 8'h44, 16'h0BAD};
    vecs[5] = '{4'b0011, 0, 0, 8'h55, 16'h7777};
    vecs[6] = '{4'b1000, 3, 3, 8'h66, 16'hF00D};
    vecs[7] = '{4'b1100, 2, 2, 8'h77, 16'h1357};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven arbitration vectors; vector 0 is the single-transaction case.
    for (int v = 0; v < 8; v++) begin
      fill(vecs[v].data, vecs[v].word);
      apply(vecs[v].mask, w);
      chk($sformatf("vec%0d_winner", v), w, RR_MODE ? vecs[v].exp_rr : vecs[v].exp_fixed);
      if (v == 0) begin
        chk("single_latency", last_rsp_cyc - last_hs_cyc, TXN_CYCLES + 2);
        chk("single_copi0", copi_reg[0], 8'hA5);
        chk("single_rsp", rsp_data, 16'h3C5A);
      end
    end

    // Full contention held for five back-to-back grants.
    do_reset();
    fill(8'hC0, 16'h2468);
    n0 = grant_log.size();
    req_valid = 4'b1111;
    wait_grants(n0 + 5, 200);
    req_valid = '0;
    exp_c = RR_MODE ? '{0, 1, 2, 3, 0} : '{0, 0, 0, 0, 0};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("contend_grant%0d", k), (grant_log.size() > n0 + k) ? grant_log[n0 + k] : -1, exp_c[k]);
    end
    wait_idle();

    // Requesters 1 and 3 held: fixed priority starves 3 until 1 withdraws.
    do_reset();
    fill(8'h5A, 16'h8421);
    n0 = grant_log.size();
    req_valid = 4'b1010;
    wait_grants(n0 + 3, 150);
    req_valid[1] = 1'b0;
    wait_grants(n0 + 4, 60);
    req_valid = '0;
    exp_c = RR_MODE ? '{1, 3, 1, 3, 0} : '{1, 1, 1, 3, 0};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("prio_grant%0d", k), (grant_log.size() > n0 + k) ? grant_log[n0 + k] : -1, exp_c[k]);
    end
    wait_idle();

    // Request 2 arrives 10 cycles into a transaction and waits for the next idle cycle.
    fill(8'h90, 16'h6C6C);
    n0 = grant_log.size();
    req_valid = 4'b0001;
    wait_grants(n0 + 1, 60);
    req_valid = '0;
    h = last_hs_cyc;
    while (cyc < h + 10) begin @(posedge clk); #1; end
    req_valid[2] = 1'b1;
    wait_grants(n0 + 2, 60);
    req_valid = '0;
    chk("rereq_winner", (grant_log.size() > n0 + 1) ? grant_log[n0 + 1] : -1, 2);
    chk("rereq_same_cycle_as_rsp", last_hs_cyc, last_rsp_cyc);
    chk("rereq_spacing", last_hs_cyc - h, TXN_CYCLES + 2);
    wait_idle();

    // Reset while the timer sits at 15: the transaction aborts silently.
    fill(8'h3E, 16'hABCD);
    n0 = grant_log.size();
    req_valid = 4'b0010;
    wait_grants(n0 + 1, 60);
    req_valid = '0;
    h = last_hs_cyc;
    while (cyc < h + 18) begin @(posedge clk); #1; end
    rc0 = rsp_count;
    #3 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_start_comm", start_comm, 0);
    chk("midrst_cs_in", CS_in, 0);
    chk("midrst_data_send_c", data_send_c, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_rsp", rsp_count, rc0);
    req_cs[3*2 +: 2]   = 2'd2;
    req_data[3*8 +: 8] = 8'h0F;
    periph_word[2]     = 16'h55AA;
    apply(4'b1000, w);
    chk("postrst_winner", w, 3);
    chk("postrst_copi2", copi_reg[2], 8'h0F);
    chk("postrst_rsp", rsp_data, 16'h55AA);

    // Random traffic: every response is matched through the scoreboard.
    for (int t = 0; t < 200; t++) begin
      rmask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        req_cs[i*2 +: 2]   = 2'($urandom_range(0, 3));
        req_data[i*8 +: 8] = 8'($urandom);
        periph_word[i]     = 16'($urandom);
      end
      apply(rmask, w);
      chk("rand_in_mask", (w >= 0) ? rmask[w[1:0]] : 1'b0, 1);
    end

    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
